// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor between the cache pmem_* port and the 64-bit burst memory.
// A 256-bit line read or write is carried out as four beats; resp_o pulses once per line.
module cacheline_adaptor #(
    parameter int unsigned s_line  = 256,
    parameter int unsigned s_burst = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,

    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int unsigned s_beats = s_line / s_burst;
    localparam int unsigned cnt_w   = $clog2(s_beats);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_read  = 2'd1;
    localparam logic [1:0] st_write = 2'd2;
    localparam logic [1:0] st_done  = 2'd3;

    logic [1:0]         state;
    logic [cnt_w-1:0]   cnt;
    logic [cnt_w-1:0]   cnt_next;
    logic               last_beat;
    logic [s_line-1:0]  rd_line;
    logic [s_line-1:0]  wr_line;
    logic [31:0]        addr;
    logic [s_burst-1:0] beat_out;
    logic [s_burst-1:0] next_beat;

    assign cnt_next  = cnt + cnt_w'(1);
    assign last_beat = (cnt == cnt_w'(s_beats - 1));

    // Beat to present after the current one is accepted.
    always_comb begin
        next_beat = '0;
        for (int unsigned i = 0; i < s_beats; i++) begin
            if (cnt_next == cnt_w'(i)) begin
                next_beat = wr_line[i*s_burst +: s_burst];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= st_idle;
            cnt      <= '0;
            rd_line  <= '0;
            wr_line  <= '0;
            addr     <= '0;
            beat_out <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (read_i) begin
                        addr  <= address_i;
                        cnt   <= '0;
                        state <= st_read;
                    end else if (write_i) begin
                        addr     <= address_i;
                        wr_line  <= line_i;
                        beat_out <= line_i[s_burst-1:0];
                        cnt      <= '0;
                        state    <= st_write;
                    end
                end
                st_read: begin
                    if (resp_i) begin
                        for (int unsigned i = 0; i < s_beats; i++) begin
                            if (cnt == cnt_w'(i)) begin
                                rd_line[i*s_burst +: s_burst] <= burst_i;
                            end
                        end
                        cnt <= cnt_next;
                        if (last_beat) begin
                            state <= st_done;
                        end
                    end
                end
                st_write: begin
                    if (resp_i) begin
                        cnt <= cnt_next;
                        // Last beat stays on burst_o after the transfer ends.
                        if (last_beat) begin
                            state <= st_done;
                        end else begin
                            beat_out <= next_beat;
                        end
                    end
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

    assign read_o    = (state == st_read);
    assign write_o   = (state == st_write);
    assign resp_o    = (state == st_done);
    assign line_o    = rd_line;
    assign address_o = addr;
    assign burst_o   = beat_out;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: per-cycle vector table for a read and a write,
// then hand sequences for gapped beats, read/write collision, mid-burst reset and back-to-back.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks   = 0;
    int failures = 0;

    cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         rst;
        logic         rd;
        logic         wr;
        logic         rsp;
        logic [31:0]  addr;
        logic [63:0]  beat;
        logic         e_rd;
        logic         e_wr;
        logic         e_resp;
        logic [31:0]  e_addr;
        logic [63:0]  e_burst;
        logic         chk_line;
        logic [255:0] e_line;
    } vec_t;

    localparam logic [63:0] w0 = 64'hFEDC_BA98_7654_CDEF;
    localparam logic [63:0] w1 = 64'h1357_9BDF_2468_ACE0;
    localparam logic [63:0] w2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] w3 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] b1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] b2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] b3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] b4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] junk = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam logic [255:0] rd_line = {b4, b3, b2, b1};

    vec_t        tbl [16];
    logic [6:0]  gap_pat;
    logic [63:0] mem [4];
    int          nw;
    logic        got_resp;

    initial begin
        rst       = 1'b1;
        read_i    = 1'b0;
        write_i   = 1'b0;
        resp_i    = 1'b0;
        burst_i   = '0;
        address_i = '0;
        line_i    = {w3, w2, w1, w0};

        //          rst   rd    wr    rsp   addr_in       beat  e_rd  e_wr  e_rsp e_addr        e_burst chk  e_line
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, junk, 1'b0, 1'b0, 1'b0, 32'h0000_0000, '0, 1'b1, '0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, junk, 1'b0, 1'b0, 1'b0, 32'h0000_0000, '0, 1'b0, '0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, b1,   1'b1, 1'b0, 1'b0, 32'h0000_2000, '0, 1'b0, '0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, b2,   1'b1, 1'b0, 1'b0, 32'h0000_2000, '0, 1'b0, '0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, b3,   1'b1, 1'b0, 1'b0, 32'h0000_2000, '0, 1'b0, '0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, b4,   1'b1, 1'b0, 1'b0, 32'h0000_2000, '0, 1'b0, '0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, junk, 1'b0, 1'b0, 1'b1, 32'h0000_2000, '0, 1'b1, rd_line};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, junk, 1'b0, 1'b0, 1'b0, 32'h0000_2000, '0, 1'b1, rd_line};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1240, junk, 1'b0, 1'b0, 1'b0, 32'h0000_2000, '0, 1'b0, '0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1240, junk, 1'b0, 1'b1, 1'b0, 32'h0000_1240, w0, 1'b0, '0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1240, junk, 1'b0, 1'b1, 1'b0, 32'h0000_1240, w1, 1'b0, '0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1240, junk, 1'b0, 1'b1, 1'b0, 32'h0000_1240, w1, 1'b0, '0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1240, junk, 1'b0, 1'b1, 1'b0, 32'h0000_1240, w2, 1'b0, '0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1240, junk, 1'b0, 1'b1, 1'b0, 32'h0000_1240, w3, 1'b0, '0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1240, junk, 1'b0, 1'b0, 1'b1, 32'h0000_1240, w3, 1'b1, rd_line};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1240, junk, 1'b0, 1'b0, 1'b0, 32'h0000_1240, w3, 1'b1, rd_line};

        // Outputs depend only on registered state, so drive and check in the same low phase.
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            rst       = tbl[r].rst;
            read_i    = tbl[r].rd;
            write_i   = tbl[r].wr;
            resp_i    = tbl[r].rsp;
            address_i = tbl[r].addr;
            burst_i   = tbl[r].beat;
            #1;
            chk1 ($sformatf("tbl%0d read_o", r),    read_o,    tbl[r].e_rd);
            chk1 ($sformatf("tbl%0d write_o", r),   write_o,   tbl[r].e_wr);
            chk1 ($sformatf("tbl%0d resp_o", r),    resp_o,    tbl[r].e_resp);
            chk32($sformatf("tbl%0d address_o", r), address_o, tbl[r].e_addr);
            chk64($sformatf("tbl%0d burst_o", r),   burst_o,   tbl[r].e_burst);
            if (tbl[r].chk_line) begin
                chk256($sformatf("tbl%0d line_o", r), line_o, tbl[r].e_line);
            end
        end

        // Gapped read: beats captured only where resp_i is high.
        gap_pat = 7'b1011001;
        @(negedge clk);
        read_i = 1'b1; address_i = 32'h0000_5000; resp_i = 1'b0; burst_i = junk;
        #1 chk1("gap accept read_o", read_o, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            resp_i  = gap_pat[k];
            burst_i = 64'hC0DE_0000_0000_0000 + 64'(k);
            #1;
            chk1($sformatf("gap%0d read_o", k), read_o, 1'b1);
            chk1($sformatf("gap%0d resp_o", k), resp_o, 1'b0);
        end
        @(negedge clk);
        resp_i = 1'b0; read_i = 1'b0; burst_i = junk;
        #1;
        chk1("gap done resp_o", resp_o, 1'b1);
        chk256("gap line_o", line_o, {64'hC0DE_0000_0000_0006, 64'hC0DE_0000_0000_0004,
                                      64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0000});
        @(negedge clk);
        #1 chk1("gap resp_o single pulse", resp_o, 1'b0);

        // Read and write requested together: read wins.
        @(negedge clk);
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_6000;
        #1 chk1("both idle write_o", write_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            resp_i  = 1'b1;
            burst_i = 64'h0000_0000_0000_00B0 + 64'(k);
            #1;
            chk1($sformatf("both%0d read_o", k), read_o, 1'b1);
            chk1($sformatf("both%0d write_o", k), write_o, 1'b0);
        end
        @(negedge clk);
        resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
        #1;
        chk1("both done resp_o", resp_o, 1'b1);
        chk1("both done write_o", write_o, 1'b0);
        chk256("both line_o", line_o, {64'h00B3, 64'h00B2, 64'h00B1, 64'h00B0});
        @(negedge clk);
        #1 chk1("both after write_o", write_o, 1'b0);

        // Reset after two beats of a read, then a clean full read.
        @(negedge clk);
        read_i = 1'b1; address_i = 32'h0000_7000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            resp_i  = 1'b1;
            burst_i = 64'h0000_0000_0000_00E0 + 64'(k);
        end
        @(negedge clk);
        resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
        #1;
        chk1 ("rst read_o", read_o, 1'b0);
        chk1 ("rst resp_o", resp_o, 1'b0);
        chk32("rst address_o", address_o, 32'h0);
        chk256("rst line_o", line_o, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_i = 1'b1; address_i = 32'h0000_7100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            resp_i  = 1'b1;
            burst_i = 64'h0000_0000_0000_00F0 + 64'(k);
        end
        @(negedge clk);
        resp_i = 1'b0; read_i = 1'b0;
        #1;
        chk1("post-rst resp_o", resp_o, 1'b1);
        chk256("post-rst line_o", line_o, {64'h00F3, 64'h00F2, 64'h00F1, 64'h00F0});

        // Write then read back-to-back through a four-beat memory model.
        @(negedge clk);
        line_i  = {64'h3C3C_0000_0000_0003, 64'h2B2B_0000_0000_0002,
                   64'h1A1A_0000_0000_0001, 64'h0909_0000_0000_0000};
        write_i = 1'b1; address_i = 32'h0000_8000; resp_i = 1'b0;
        nw = 0;
        got_resp = 1'b0;
        for (int t = 0; t < 12 && !got_resp; t++) begin
            @(negedge clk);
            #1;
            if (resp_o) begin
                got_resp = 1'b1;
                write_i = 1'b0; read_i = 1'b1; resp_i = 1'b0;
            end else if (write_o && nw < 4) begin
                mem[nw] = burst_o;
                nw++;
                resp_i = 1'b1;
            end else begin
                resp_i = 1'b0;
            end
        end
        chk1 ("b2b write resp_o seen", got_resp, 1'b1);
        chk32("b2b write beat count", 32'(nw), 32'd4);
        chk64("b2b mem beat0", mem[0], 64'h0909_0000_0000_0000);
        chk64("b2b mem beat3", mem[3], 64'h3C3C_0000_0000_0003);
        @(negedge clk);
        #1 chk1("b2b idle read_o", read_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("b2b read%0d read_o", k), read_o, 1'b1);
            resp_i  = 1'b1;
            burst_i = mem[k];
        end
        chk32("b2b read address_o", address_o, 32'h0000_8000);
        @(negedge clk);
        resp_i = 1'b0; read_i = 1'b0;
        #1;
        chk1("b2b read resp_o", resp_o, 1'b1);
        chk256("b2b read line_o", line_o, {64'h3C3C_0000_0000_0003, 64'h2B2B_0000_0000_0002,
                                           64'h1A1A_0000_0000_0001, 64'h0909_0000_0000_0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
